// File: rtl/decode_ctrl_stage_if.sv
// rtl/decode_ctrl_stage_if.sv - ID-side decode inputs and EX-side registered control bundle
// Purpose: groups the decode stage's instruction fields and its registered control outputs.
// Ports (signals):
//   ID side : valid_i, stall_i, flush_i, op_i, funct3_i, funct7b5_i, rd_i
//   EX side : valid_o, RegWrite, ResultSrc, MemWrite, Jump, Branch, BranchType, ALUSrc,
//             ALUSrcA, ImmSrc, ALUOp, funct7b5_o, illegal_o, illegal_cnt
// Modports: master drives the ID side and observes EX; slave is the decode stage itself.
interface decode_ctrl_stage_if #(
    parameter int OP_WIDTH  = 7,
    parameter int RD_W      = 5,
    parameter int ILL_CNT_W = 8
);
    logic                 valid_i;
    logic                 stall_i;
    logic                 flush_i;
    logic [OP_WIDTH-1:0]  op_i;
    logic [2:0]           funct3_i;
    logic                 funct7b5_i;
    logic [RD_W-1:0]      rd_i;

    logic                 valid_o;
    logic [2:0]           RegWrite;
    logic [1:0]           ResultSrc;
    logic [1:0]           MemWrite;
    logic                 Jump;
    logic                 Branch;
    logic [2:0]           BranchType;
    logic                 ALUSrc;
    logic                 ALUSrcA;
    logic [2:0]           ImmSrc;
    logic [1:0]           ALUOp;
    logic                 funct7b5_o;
    logic                 illegal_o;
    logic [ILL_CNT_W-1:0] illegal_cnt;

    modport master (
        output valid_i, stall_i, flush_i, op_i, funct3_i, funct7b5_i, rd_i,
        input  valid_o, RegWrite, ResultSrc, MemWrite, Jump, Branch, BranchType,
               ALUSrc, ALUSrcA, ImmSrc, ALUOp, funct7b5_o, illegal_o, illegal_cnt
    );

    modport slave (
        input  valid_i, stall_i, flush_i, op_i, funct3_i, funct7b5_i, rd_i,
        output valid_o, RegWrite, ResultSrc, MemWrite, Jump, Branch, BranchType,
               ALUSrc, ALUSrcA, ImmSrc, ALUOp, funct7b5_o, illegal_o, illegal_cnt
    );
endinterface

// File: rtl/decode_ctrl_stage.sv
// rtl/decode_ctrl_stage.sv - RV32I main control decoder fused with the ID/EX control register
// Purpose: decodes opcode/funct3/funct7[5]/rd in ID and registers the control fields for EX.
//   Edge priority: flush (bubble) > stall (hold) > load (decode, or bubble if invalid/illegal).
// Ports:
//   clk   : core clock
//   rst_n : asynchronous active-low reset, clears every output
//   bus   : decode_ctrl_stage_if.slave (ID-side inputs, EX-side registered controls)
// Optional feature: define ILLEGAL_TRAP_EN to enable illegal_o and the saturating illegal_cnt;
//   otherwise both are tied to 0 (illegal instructions still become bubbles).
module decode_ctrl_stage #(
    parameter int OP_WIDTH  = 7,
    parameter int RD_W      = 5,
    parameter int ILL_CNT_W = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    decode_ctrl_stage_if.slave bus
);
    localparam logic [OP_WIDTH-1:0] op_load   = 7'b0000011;
    localparam logic [OP_WIDTH-1:0] op_store  = 7'b0100011;
    localparam logic [OP_WIDTH-1:0] op_r      = 7'b0110011;
    localparam logic [OP_WIDTH-1:0] op_i_alu  = 7'b0010011;
    localparam logic [OP_WIDTH-1:0] op_branch = 7'b1100011;
    localparam logic [OP_WIDTH-1:0] op_lui    = 7'b0110111;
    localparam logic [OP_WIDTH-1:0] op_auipc  = 7'b0010111;
    localparam logic [OP_WIDTH-1:0] op_jal    = 7'b1101111;
    localparam logic [OP_WIDTH-1:0] op_jalr   = 7'b1100111;
    localparam logic [OP_WIDTH-1:0] op_none   = 7'b0000000;

    typedef struct packed {
        logic [2:0] reg_write;
        logic [1:0] result_src;
        logic [1:0] mem_write;
        logic       jump;
        logic       branch;
        logic [2:0] branch_type;
        logic       alu_src;
        logic       alu_src_a;
        logic [2:0] imm_src;
        logic [1:0] alu_op;
        logic       funct7b5;
    } ctrl_t;

    logic [OP_WIDTH-1:0] op;
    logic [2:0]          f3;
    logic [RD_W-1:0]     rd;
    ctrl_t               dec;
    ctrl_t               ctrl_q;
    logic                dec_illegal;
    logic                valid_q;

    assign op = bus.op_i;
    assign f3 = bus.funct3_i;
    assign rd = bus.rd_i;

    always_comb begin
        dec         = '0;
        dec_illegal = 1'b0;
        case (op)
            op_load: begin
                dec.result_src = 2'b01;
                dec.alu_src    = 1'b1;
                // Size code: 1 word, 2 half, 3 byte, 6 hu, 7 bu
                case (f3)
                    3'b000:  dec.reg_write = 3'd3;
                    3'b001:  dec.reg_write = 3'd2;
                    3'b010:  dec.reg_write = 3'd1;
                    3'b100:  dec.reg_write = 3'd7;
                    3'b101:  dec.reg_write = 3'd6;
                    default: dec_illegal   = 1'b1;
                endcase
            end
            op_store: begin
                dec.alu_src = 1'b1;
                dec.imm_src = 3'b001;
                // sb/sh/sw (000/001/010) map to 3/2/1
                if (f3 <= 3'b010) dec.mem_write = 2'd3 - f3[1:0];
                else              dec_illegal   = 1'b1;
            end
            op_r: begin
                dec.reg_write = 3'd1;
                dec.alu_op    = 2'b10;
            end
            op_i_alu: begin
                dec.reg_write = 3'd1;
                dec.alu_src   = 1'b1;
                dec.alu_op    = 2'b10;
            end
            op_branch: begin
                dec.branch      = 1'b1;
                dec.branch_type = f3;
                dec.imm_src     = 3'b010;
                dec.alu_op      = 2'b01;
                dec_illegal     = (f3[2:1] == 2'b01);
            end
            op_lui: begin
                dec.reg_write = 3'd1;
                dec.alu_src   = 1'b1;
                dec.imm_src   = 3'b100;
                dec.alu_op    = 2'b11;
            end
            op_auipc: begin
                dec.reg_write = 3'd1;
                dec.alu_src   = 1'b1;
                dec.alu_src_a = 1'b1;
                dec.imm_src   = 3'b100;
            end
            op_jal: begin
                dec.reg_write  = 3'd1;
                dec.result_src = 2'b10;
                dec.jump       = 1'b1;
                dec.imm_src    = 3'b011;
            end
            op_jalr: begin
                dec.reg_write  = 3'd1;
                dec.result_src = 2'b10;
                dec.jump       = 1'b1;
                dec.alu_src    = 1'b1;
                dec_illegal    = (f3 != 3'b000);
            end
            op_none: ;  // post-reset fetch: all-zero controls, not illegal
            default: dec_illegal = 1'b1;
        endcase
        // x0 destination: suppress the write only; memory side effects stay
        if (rd == '0) dec.reg_write = 3'b000;
        dec.funct7b5 = bus.funct7b5_i;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= 1'b0;
            ctrl_q  <= '0;
        end else if (bus.flush_i) begin
            valid_q <= 1'b0;
            ctrl_q  <= '0;
        end else if (!bus.stall_i) begin
            if (bus.valid_i && !dec_illegal) begin
                valid_q <= 1'b1;
                ctrl_q  <= dec;
            end else begin
                valid_q <= 1'b0;
                ctrl_q  <= '0;
            end
        end
    end

    assign bus.valid_o    = valid_q;
    assign bus.RegWrite   = ctrl_q.reg_write;
    assign bus.ResultSrc  = ctrl_q.result_src;
    assign bus.MemWrite   = ctrl_q.mem_write;
    assign bus.Jump       = ctrl_q.jump;
    assign bus.Branch     = ctrl_q.branch;
    assign bus.BranchType = ctrl_q.branch_type;
    assign bus.ALUSrc     = ctrl_q.alu_src;
    assign bus.ALUSrcA    = ctrl_q.alu_src_a;
    assign bus.ImmSrc     = ctrl_q.imm_src;
    assign bus.ALUOp      = ctrl_q.alu_op;
    assign bus.funct7b5_o = ctrl_q.funct7b5;

`ifdef ILLEGAL_TRAP_EN
    logic                 illegal_q;
    logic [ILL_CNT_W-1:0] ill_cnt_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            illegal_q <= 1'b0;
            ill_cnt_q <= '0;
        end else if (bus.flush_i) begin
            illegal_q <= 1'b0;
        end else if (!bus.stall_i) begin
            illegal_q <= bus.valid_i && dec_illegal;
            if (bus.valid_i && dec_illegal && !(&ill_cnt_q))
                ill_cnt_q <= ill_cnt_q + ILL_CNT_W'(1);
        end
    end

    assign bus.illegal_o   = illegal_q;
    assign bus.illegal_cnt = ill_cnt_q;
`else
    assign bus.illegal_o   = 1'b0;
    assign bus.illegal_cnt = '0;
`endif
endmodule

// File: tb/tb_decode_ctrl_stage.sv
// tb/tb_decode_ctrl_stage.sv - self-checking bench for decode_ctrl_stage
module tb_decode_ctrl_stage;
    localparam int ILL_CNT_W = 8;
    localparam int CNT_MAX   = (1 << ILL_CNT_W) - 1;
`ifdef ILLEGAL_TRAP_EN
    localparam bit trap_en = 1'b1;
`else
    localparam bit trap_en = 1'b0;
`endif

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    decode_ctrl_stage_if #(.OP_WIDTH(7), .RD_W(5), .ILL_CNT_W(ILL_CNT_W)) bus ();

    decode_ctrl_stage #(.OP_WIDTH(7), .RD_W(5), .ILL_CNT_W(ILL_CNT_W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    typedef struct packed {
        logic [2:0] rw;
        logic [1:0] rs;
        logic [1:0] mw;
        logic       j;
        logic       b;
        logic [2:0] bt;
        logic       as;
        logic       asa;
        logic [2:0] imm;
        logic [1:0] aluop;
        logic       f7;
    } exp_t;

    int   checks = 0;
    int   errors = 0;
    bit   cmp_en = 1'b0;
    logic m_valid = 1'b0;
    exp_t m_e = '0;
    logic m_ill = 1'b0;
    int   m_cnt = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
        end
    endtask

    // Reference decode: each table row is the spec's control string; size codes and
    // legality are then derived arithmetically from funct3.
    function automatic void ref_decode(input logic [6:0] op, input logic [2:0] f3,
                                       input logic f7, input logic [4:0] rd,
                                       output exp_t e, output logic ill);
        logic [15:0] row;
        int ld_size [8];
        ld_size = '{3, 2, 1, 0, 7, 6, 0, 0};
        row = '0;
        ill = 1'b0;
        e   = '0;
        case (op)
            7'b0000011: row = {3'd0, 2'b01, 2'd0, 1'b0, 1'b0, 1'b1, 1'b0, 3'b000, 2'b00};
            7'b0100011: row = {3'd0, 2'b00, 2'd0, 1'b0, 1'b0, 1'b1, 1'b0, 3'b001, 2'b00};
            7'b0110011: row = {3'd1, 2'b00, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0, 3'b000, 2'b10};
            7'b0010011: row = {3'd1, 2'b00, 2'd0, 1'b0, 1'b0, 1'b1, 1'b0, 3'b000, 2'b10};
            7'b1100011: row = {3'd0, 2'b00, 2'd0, 1'b0, 1'b1, 1'b0, 1'b0, 3'b010, 2'b01};
            7'b0110111: row = {3'd1, 2'b00, 2'd0, 1'b0, 1'b0, 1'b1, 1'b0, 3'b100, 2'b11};
            7'b0010111: row = {3'd1, 2'b00, 2'd0, 1'b0, 1'b0, 1'b1, 1'b1, 3'b100, 2'b00};
            7'b1101111: row = {3'd1, 2'b10, 2'd0, 1'b1, 1'b0, 1'b0, 1'b0, 3'b011, 2'b00};
            7'b1100111: row = {3'd1, 2'b10, 2'd0, 1'b1, 1'b0, 1'b1, 1'b0, 3'b000, 2'b00};
            7'b0000000: row = '0;
            default:    ill = 1'b1;
        endcase
        {e.rw, e.rs, e.mw, e.j, e.b, e.as, e.asa, e.imm, e.aluop} = row;
        if (op == 7'b0000011) begin
            e.rw = 3'(ld_size[f3]);
            ill  = (ld_size[f3] == 0);
        end
        if (op == 7'b0100011) begin
            if (int'(f3) < 3) e.mw = 2'(3 - int'(f3));
            else              ill  = 1'b1;
        end
        if (op == 7'b1100011) begin
            e.bt = f3;
            ill  = (f3 == 3'd2) || (f3 == 3'd3);
        end
        if (op == 7'b1100111) ill = (f3 != 3'd0);
        if (rd == 5'd0) e.rw = 3'd0;
        e.f7 = f7;
    endfunction

    // Behavioural model of the ID/EX register
    always @(posedge clk or negedge rst_n) begin
        exp_t e;
        logic ill;
        if (!rst_n) begin
            m_valid = 1'b0; m_e = '0; m_ill = 1'b0; m_cnt = 0;
        end else if (bus.flush_i) begin
            m_valid = 1'b0; m_e = '0; m_ill = 1'b0;
        end else if (!bus.stall_i) begin
            ref_decode(bus.op_i, bus.funct3_i, bus.funct7b5_i, bus.rd_i, e, ill);
            if (bus.valid_i && !ill) begin
                m_valid = 1'b1; m_e = e;
            end else begin
                m_valid = 1'b0; m_e = '0;
            end
            m_ill = bus.valid_i && ill;
            if (m_ill && m_cnt < CNT_MAX) m_cnt++;
        end
    end

    // Per-cycle compare against the model, away from the active edge
    always @(negedge clk) begin
        if (cmp_en) begin
            check("valid_o",    32'(bus.valid_o),    32'(m_valid));
            check("RegWrite",   32'(bus.RegWrite),   32'(m_e.rw));
            check("ResultSrc",  32'(bus.ResultSrc),  32'(m_e.rs));
            check("MemWrite",   32'(bus.MemWrite),   32'(m_e.mw));
            check("Jump",       32'(bus.Jump),       32'(m_e.j));
            check("Branch",     32'(bus.Branch),     32'(m_e.b));
            check("BranchType", 32'(bus.BranchType), 32'(m_e.bt));
            check("ALUSrc",     32'(bus.ALUSrc),     32'(m_e.as));
            check("ALUSrcA",    32'(bus.ALUSrcA),    32'(m_e.asa));
            check("ImmSrc",     32'(bus.ImmSrc),     32'(m_e.imm));
            check("ALUOp",      32'(bus.ALUOp),      32'(m_e.aluop));
            check("funct7b5_o", 32'(bus.funct7b5_o), 32'(m_e.f7));
            check("illegal_o",  32'(bus.illegal_o),  trap_en ? 32'(m_ill) : 32'd0);
            check("illegal_cnt", 32'(bus.illegal_cnt), trap_en ? 32'(m_cnt) : 32'd0);
        end
    end

    task automatic step(input logic v, input logic st, input logic fl, input logic [6:0] op,
                        input logic [2:0] f3, input logic f7, input logic [4:0] rd);
        bus.valid_i    = v;
        bus.stall_i    = st;
        bus.flush_i    = fl;
        bus.op_i       = op;
        bus.funct3_i   = f3;
        bus.funct7b5_i = f7;
        bus.rd_i       = rd;
        @(posedge clk);
        #1;
    endtask

    logic [6:0] legal_ops [10];

    initial begin
        legal_ops = '{7'b0000011, 7'b0100011, 7'b0110011, 7'b0010011, 7'b1100011,
                      7'b0110111, 7'b0010111, 7'b1101111, 7'b1100111, 7'b0000000};
        bus.valid_i = 1'b0; bus.stall_i = 1'b0; bus.flush_i = 1'b0;
        bus.op_i = '0; bus.funct3_i = '0; bus.funct7b5_i = 1'b0; bus.rd_i = '0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        cmp_en = 1'b1;

        check("rst valid_o",  32'(bus.valid_o), 32'd0);
        check("rst RegWrite", 32'(bus.RegWrite), 32'd0);
        check("rst ImmSrc",   32'(bus.ImmSrc), 32'd0);
        check("rst illcnt",   32'(bus.illegal_cnt), 32'd0);

        step(1, 0, 0, 7'b0110011, 3'd0, 1'b0, 5'd5);
        check("R valid_o",  32'(bus.valid_o), 32'd1);
        check("R RegWrite", 32'(bus.RegWrite), 32'd1);
        check("R ALUOp",    32'(bus.ALUOp), 32'd2);
        check("R ALUSrc",   32'(bus.ALUSrc), 32'd0);

        step(1, 0, 0, 7'b0000011, 3'b101, 1'b0, 5'd3);
        check("lhu RegWrite",  32'(bus.RegWrite), 32'd6);
        check("lhu ResultSrc", 32'(bus.ResultSrc), 32'd1);
        step(1, 0, 0, 7'b0000011, 3'b101, 1'b0, 5'd0);
        check("lhu x0 RegWrite",  32'(bus.RegWrite), 32'd0);
        check("lhu x0 ResultSrc", 32'(bus.ResultSrc), 32'd1);

        step(1, 0, 0, 7'b0100011, 3'b000, 1'b0, 5'd9);
        check("sb MemWrite", 32'(bus.MemWrite), 32'd3);
        check("sb ImmSrc",   32'(bus.ImmSrc), 32'd1);
        step(1, 0, 0, 7'b1100011, 3'b110, 1'b0, 5'd4);
        check("bltu Branch",     32'(bus.Branch), 32'd1);
        check("bltu BranchType", 32'(bus.BranchType), 32'd6);
        check("bltu ImmSrc",     32'(bus.ImmSrc), 32'd2);

        step(1, 0, 0, 7'b0010111, 3'b000, 1'b0, 5'd7);
        for (int i = 0; i < 3; i++) begin
            step(1, 1, 0, 7'b0110011, 3'b000, 1'b1, 5'd8);
            check("stall ALUSrcA", 32'(bus.ALUSrcA), 32'd1);
            check("stall ImmSrc",  32'(bus.ImmSrc), 32'd4);
            check("stall valid_o", 32'(bus.valid_o), 32'd1);
        end
        step(1, 1, 1, 7'b0110011, 3'b000, 1'b1, 5'd8);
        check("flush valid_o", 32'(bus.valid_o), 32'd0);
        check("flush ALUSrcA", 32'(bus.ALUSrcA), 32'd0);
        check("flush ImmSrc",  32'(bus.ImmSrc), 32'd0);

        for (int i = 0; i < 3000; i++) begin
            logic [6:0] op;
            logic [4:0] rd;
            if ($urandom_range(5) == 0) op = 7'($urandom);
            else                        op = legal_ops[$urandom_range(9)];
            rd = ($urandom_range(3) == 0) ? 5'd0 : 5'($urandom);
            step($urandom_range(4) != 0, $urandom_range(4) == 0, $urandom_range(9) == 0,
                 op, 3'($urandom), 1'($urandom), rd);
        end

        for (int i = 0; i < 300; i++) step(1, 0, 0, 7'b1111111, 3'($urandom), 1'b0, 5'd1);
        check("ill valid_o",   32'(bus.valid_o), 32'd0);
        check("ill illegal_o", 32'(bus.illegal_o), trap_en ? 32'd1 : 32'd0);
        check("ill count",     32'(bus.illegal_cnt), trap_en ? 32'd255 : 32'd0);

        step(1, 0, 0, 7'b0010111, 3'b000, 1'b1, 5'd2);
        check("pre-rst valid_o", 32'(bus.valid_o), 32'd1);
        #2 rst_n = 1'b0;
        #1;
        check("async valid_o",  32'(bus.valid_o), 32'd0);
        check("async RegWrite", 32'(bus.RegWrite), 32'd0);
        check("async ALUSrcA",  32'(bus.ALUSrcA), 32'd0);
        check("async ImmSrc",   32'(bus.ImmSrc), 32'd0);
        check("async f7",       32'(bus.funct7b5_o), 32'd0);
        check("async illcnt",   32'(bus.illegal_cnt), 32'd0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        step(1, 0, 0, 7'b1101111, 3'b000, 1'b0, 5'd1);
        check("jal ResultSrc", 32'(bus.ResultSrc), 32'd2);
        check("jal ImmSrc",    32'(bus.ImmSrc), 32'd3);
        step(0, 0, 0, 7'b0110011, 3'b000, 1'b0, 5'd1);
        check("bubble valid_o", 32'(bus.valid_o), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
